vga_scan_gen: RTL and testbench

VGA 640x480@60 Hz scan generator: the source end of the pixel-request interface that the ground, dinosaur and obstacle layers consume. Issues `row_addr`/`col_addr` for each visible pixel and samples the composited colour `px_data` one clock later. Emits aligned RGB, HSYNC and VSYNC to the board DAC. Drives the per-frame `fresh` strobe whose falling edge the layers use to advance scroll state during vertical blanking.

---
 rtl/vga_scan_gen.sv | 127 ++++++++++++
 tb/tb_vga_scan_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_gen
// Purpose  : VGA 640x480@60 scan generator; issues pixel addresses, samples
//            px_data one clock later, emits aligned RGB/HSYNC/VSYNC and the
//            per-frame 'fresh' strobe. Optional macro: VGA_BORDER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan_gen #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clk,
    input  logic        N_rst,
    output logic [8:0]  row_addr,
    output logic [9:0]  col_addr,
    input  logic [11:0] px_data,
    output logic        fresh,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b
);

    localparam logic [9:0] c_h_vis   = 10'(H_VIS);
    localparam logic [9:0] c_h_last  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_hs_beg  = 10'(H_VIS + H_FP);
    localparam logic [9:0] c_hs_end  = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] c_v_vis   = 10'(V_VIS);
    localparam logic [9:0] c_v_last  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] c_vs_beg  = 10'(V_VIS + V_FP);
    localparam logic [9:0] c_vs_end  = 10'(V_VIS + V_FP + V_SYNC);

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        de1_q, de1_d;
    logic [9:0]  col_q, col_d;
    logic [8:0]  row_q, row_d;
    logic        hs1_q, hs1_d;
    logic        vs1_q, vs1_d;
    logic        fresh_q, fresh_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, vs_q;

    always_comb begin
        h_cnt_d = (h_cnt_q == c_h_last) ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == c_h_last) begin
            v_cnt_d = (v_cnt_q == c_v_last) ? 10'd0 : v_cnt_q + 10'd1;
        end
        de1_d   = (h_cnt_q < c_h_vis) && (v_cnt_q < c_v_vis);
        col_d   = de1_d ? h_cnt_q : 10'h3FF;
        row_d   = de1_d ? v_cnt_q[8:0] : 9'h1FF;
        hs1_d   = !((h_cnt_q >= c_hs_beg) && (h_cnt_q < c_hs_end));
        vs1_d   = !((v_cnt_q >= c_vs_beg) && (v_cnt_q < c_vs_end));
        fresh_d = (v_cnt_q < c_v_vis);
    end

`ifdef VGA_BORDER_EN
    logic border1_q, border1_d;

    // Border flag travels with stage 1 so both builds share the same latency.
    always_comb begin
        border1_d = de1_d && ((h_cnt_q == 10'd0) || (h_cnt_q == c_h_vis - 10'd1) ||
                              (v_cnt_q == 10'd0) || (v_cnt_q == c_v_vis - 10'd1));
        rgb_d     = !de1_q ? 12'h000 : (border1_q ? 12'hFFF : px_data);
    end

    always_ff @(posedge clk or negedge N_rst) begin
        if (!N_rst) begin
            border1_q <= 1'b0;
        end else begin
            border1_q <= border1_d;
        end
    end
`else
    always_comb begin
        rgb_d = de1_q ? px_data : 12'h000;
    end
`endif

    always_ff @(posedge clk or negedge N_rst) begin
        if (!N_rst) begin
            h_cnt_q <= 10'd0;
            v_cnt_q <= 10'd0;
            de1_q   <= 1'b0;
            col_q   <= 10'h3FF;
            row_q   <= 9'h1FF;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            fresh_q <= 1'b0;
            rgb_q   <= 12'h000;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            de1_q   <= de1_d;
            col_q   <= col_d;
            row_q   <= row_d;
            hs1_q   <= hs1_d;
            vs1_q   <= vs1_d;
            fresh_q <= fresh_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs1_q;
            vs_q    <= vs1_q;
        end
    end

    assign row_addr = row_q;
    assign col_addr = col_q;
    assign fresh    = fresh_q;
    assign hs       = hs_q;
    assign vs       = vs_q;
    assign r        = rgb_q[11:8];
    assign g        = rgb_q[7:4];
    assign b        = rgb_q[3:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scan_gen
// Purpose  : Scoreboard bench for vga_scan_gen: a reduced-geometry instance
//            checked cycle by cycle against a pixel-index model, plus a
//            full-size instance checked over its first lines.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scan_gen;

    localparam int SH_VIS = 40, SH_FP = 4, SH_SYNC = 6, SH_BP = 6;
    localparam int SV_VIS = 24, SV_FP = 3, SV_SYNC = 2, SV_BP = 4;
    localparam int SH_TOT = SH_VIS + SH_FP + SH_SYNC + SH_BP;
    localparam int SV_TOT = SV_VIS + SV_FP + SV_SYNC + SV_BP;
    localparam int S_FRAME = SH_TOT * SV_TOT;
    localparam int FULL_EDGES = 1700;

    typedef struct {
        logic [8:0]  row;
        logic [9:0]  col;
        logic        fresh;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        N_rst = 1'b0;
    logic [11:0] seed = 12'h000;
    bit          go_full = 1'b0;

    logic [8:0]  row_s, row_f;
    logic [9:0]  col_s, col_f;
    logic [11:0] px_s, px_f;
    logic        fresh_s, hs_s, vs_s, fresh_f, hs_f, vs_f;
    logic [3:0]  r_s, g_s, b_s, r_f, g_f, b_f;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    function automatic logic [11:0] pxfn(input logic [8:0] row, input logic [9:0] col,
                                          input logic [11:0] sd);
        return {row[5:0], 6'b0} ^ {2'b0, col} ^ sd;
    endfunction

    assign px_s = pxfn(row_s, col_s, seed);
    assign px_f = {2'b0, col_f};

    vga_scan_gen #(
        .H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
        .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
    ) dut_s (
        .clk(clk), .N_rst(N_rst), .row_addr(row_s), .col_addr(col_s), .px_data(px_s),
        .fresh(fresh_s), .hs(hs_s), .vs(vs_s), .r(r_s), .g(g_s), .b(b_s)
    );

    vga_scan_gen dut_f (
        .clk(clk), .N_rst(N_rst), .row_addr(row_f), .col_addr(col_f), .px_data(px_f),
        .fresh(fresh_f), .hs(hs_f), .vs(vs_f), .r(r_f), .g(g_f), .b(b_f)
    );

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp_v);
        end
    endtask

    function automatic int fpos(input longint e);
        longint m;
        m = e % S_FRAME;
        if (m < 0) m += S_FRAME;
        return int'(m);
    endfunction

    function automatic exp_t reset_rec();
        exp_t x;
        x.row = 9'h1FF; x.col = 10'h3FF; x.fresh = 1'b0;
        x.hs = 1'b1; x.vs = 1'b1; x.rgb = 12'h000;
        return x;
    endfunction

    // After the e-th clock since release, the address stage shows scan
    // position e-1 and the colour/sync stage shows position e-2.
    function automatic exp_t model(input longint e, input logic [11:0] sd);
        exp_t x;
        int p1, p2, h1, v1, h2, v2;
        bit act1, act2, border;
        p1 = fpos(e - 1); h1 = p1 % SH_TOT; v1 = p1 / SH_TOT;
        p2 = fpos(e - 2); h2 = p2 % SH_TOT; v2 = p2 / SH_TOT;
        act1 = (h1 < SH_VIS) && (v1 < SV_VIS);
        act2 = (h2 < SH_VIS) && (v2 < SV_VIS);
        x.col   = act1 ? 10'(h1) : 10'h3FF;
        x.row   = act1 ? 9'(v1) : 9'h1FF;
        x.fresh = (v1 < SV_VIS);
        x.hs    = !((h2 >= SH_VIS + SH_FP) && (h2 < SH_VIS + SH_FP + SH_SYNC));
        x.vs    = !((v2 >= SV_VIS + SV_FP) && (v2 < SV_VIS + SV_FP + SV_SYNC));
`ifdef VGA_BORDER_EN
        border = (h2 == 0) || (h2 == SH_VIS - 1) || (v2 == 0) || (v2 == SV_VIS - 1);
`else
        border = 1'b0;
`endif
        x.rgb = !act2 ? 12'h000 : (border ? 12'hFFF : pxfn(9'(v2), 10'(h2), sd));
        return x;
    endfunction

    // Monitor: one expected record per clock, compared mid-cycle.
    always @(negedge clk) begin : monitor
        exp_t x;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check("row_addr", {3'b0, row_s}, {3'b0, x.row});
            check("col_addr", {2'b0, col_s}, {2'b0, x.col});
            check("fresh", {11'b0, fresh_s}, {11'b0, x.fresh});
            check("hs", {11'b0, hs_s}, {11'b0, x.hs});
            check("vs", {11'b0, vs_s}, {11'b0, x.vs});
            check("rgb", {r_s, g_s, b_s}, x.rgb);
        end
    end

    longint e = 0;

    task automatic step();
        @(posedge clk);
        if (!N_rst) begin
            sb_q.push_back(reset_rec());
        end else begin
            e++;
            sb_q.push_back(model(e, seed));
        end
    endtask

    task automatic check_async_reset();
        check("async row_addr", {3'b0, row_s}, 12'h1FF);
        check("async col_addr", {2'b0, col_s}, 12'h3FF);
        check("async fresh", {11'b0, fresh_s}, 12'h000);
        check("async hs", {11'b0, hs_s}, 12'h001);
        check("async vs", {11'b0, vs_s}, 12'h001);
        check("async rgb", {r_s, g_s, b_s}, 12'h000);
    endtask

    // Full 640x480 geometry over the first lines after the initial release.
    initial begin : full_chk
        int hs_fall;
        int hs_low;
        bit prev_hs;
        hs_fall = -1; hs_low = 0; prev_hs = 1'b1;
        wait (go_full);
        for (int k = 1; k <= FULL_EDGES; k++) begin
            int h1, v1, h2, v2;
            bit act2;
            logic [11:0] exp_rgb;
            @(posedge clk); #1;
            h1 = (k - 1) % 800; v1 = (k - 1) / 800;
            h2 = (k + 798) % 800; v2 = (k >= 2) ? (k - 2) / 800 : 524;
            act2 = (h2 < 640) && (v2 < 480);
`ifdef VGA_BORDER_EN
            exp_rgb = !act2 ? 12'h000 :
                      ((h2 == 0 || h2 == 639 || v2 == 0 || v2 == 479) ? 12'hFFF : 12'(h2));
`else
            exp_rgb = act2 ? 12'(h2) : 12'h000;
`endif
            check("full col_addr", {2'b0, col_f}, (h1 < 640) ? 12'(h1) : 12'h3FF);
            check("full row_addr", {3'b0, row_f}, (h1 < 640) ? 12'(v1) : 12'h1FF);
            check("full hs", {11'b0, hs_f}, (h2 >= 656 && h2 < 752) ? 12'h000 : 12'h001);
            check("full vs", {11'b0, vs_f}, 12'h001);
            check("full fresh", {11'b0, fresh_f}, 12'h001);
            check("full rgb", {r_f, g_f, b_f}, exp_rgb);
            if (prev_hs && !hs_f && hs_fall < 0) hs_fall = k;
            if (!hs_f && hs_fall > 0 && k < hs_fall + 200) hs_low++;
            prev_hs = hs_f;
        end
        check("full hs fall edge", 12'(hs_fall), 12'd658);
        check("full hs width", 12'(hs_low), 12'd96);
    end

    initial begin : stim
        int target;
        int guard;
        seed  = 12'($urandom);
        N_rst = 1'b0;
        e     = 0;
        repeat (10) step();
        @(negedge clk); #1;
        N_rst   = 1'b1;
        go_full = 1'b1;
        repeat (2 * S_FRAME + int'($urandom_range(0, 200))) step();

        for (int it = 0; it < 2; it++) begin
            target = int'($urandom_range(1, SV_VIS - 2)) * SH_TOT +
                     int'($urandom_range(1, SH_VIS - 2));
            guard = 0;
            while (fpos(e) != target && guard < S_FRAME + 1) begin
                step();
                guard++;
            end
            check("reach reset point", 12'(guard <= S_FRAME), 12'h001);
            @(negedge clk); #1;
            N_rst = 1'b0;
            e     = 0;
            #1;
            check_async_reset();
            seed = 12'($urandom);
            repeat (3) step();
            @(negedge clk); #1;
            N_rst = 1'b1;
            repeat (S_FRAME + int'($urandom_range(10, 300))) step();
        end

        @(negedge clk); #1;
        check("scoreboard drained", 12'(sb_q.size()), 12'h000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
